// File: rtl/mem_address_exec_stage_pkg.sv
// Shared types for the memory-pipe execution stage.
// Holds the access-size enum, the per-lane result record, the bypass select
// width and the flush range test used by this and other backend stages.
package mem_address_exec_stage_pkg;

  // Active-list pointer width carried in the lane record.
  localparam int unsigned AlPtrW = 6;
  // Bypass select code width: 0 = register-read operand, 1..BYP_SRC = bypass.
  localparam int unsigned SelW   = 2;

  typedef enum logic [1:0] {
    SizeByte = 2'd0,
    SizeHalf = 2'd1,
    SizeWord = 2'd2,
    SizeRsvd = 2'd3
  } mem_access_size_e;

  typedef struct packed {
    logic [31:0]       addr;
    logic [31:0]       wdata;
    logic [3:0]        be;
    logic              misaligned;
    logic              is_store;
    logic [AlPtrW-1:0] al_ptr;
  } lane_res_t;

  // True when p lies in the flushed range [head, tail) of the circular active
  // list; head == tail is an empty range unless all ops are flushed.
  function automatic logic flush_range_hit(input logic              req,
                                           input logic              all,
                                           input logic [AlPtrW-1:0] head,
                                           input logic [AlPtrW-1:0] tail,
                                           input logic [AlPtrW-1:0] p);
    logic hit;
    hit = 1'b0;
    if (req) begin
      if (all) begin
        hit = 1'b1;
      end else if (head < tail) begin
        hit = (p >= head) && (p < tail);
      end else if (head > tail) begin
        hit = (p >= head) || (p < tail);
      end
    end
    return hit;
  endfunction

endpackage

// File: rtl/mem_address_exec_stage_if.sv
// Bundle of the register-read, bypass, flush, result and issue-queue release
// signals of the memory execution stage. clk/rst are not part of the bundle.
//   master : the surrounding backend (drives in_*, stall/clear/flush, reads results)
//   slave  : the execution stage itself
interface mem_address_exec_stage_if #(
  parameter int unsigned LANES    = 2,
  parameter int unsigned AL_PTR_W = 6,
  parameter int unsigned IQ_PTR_W = 4,
  parameter int unsigned BYP_SRC  = 2
);
  logic                         stall;
  logic                         clear;
  logic [LANES-1:0]             in_valid;
  logic [LANES*AL_PTR_W-1:0]    in_al_ptr;
  logic [LANES*32-1:0]          in_opnd_a;
  logic [LANES*32-1:0]          in_opnd_b;
  logic [LANES*2-1:0]           in_sel_a;
  logic [LANES*2-1:0]           in_sel_b;
  logic [BYP_SRC*32-1:0]        byp_data;
  logic [LANES*12-1:0]          in_imm;
  logic [LANES*2-1:0]           in_size;
  logic [LANES-1:0]             in_is_store;
  logic [LANES-1:0]             in_replay;
  logic [LANES*IQ_PTR_W-1:0]    in_iq_ptr;
  logic                         flush_req;
  logic                         flush_all;
  logic [AL_PTR_W-1:0]          flush_head;
  logic [AL_PTR_W-1:0]          flush_tail;
  logic [LANES-1:0]             out_valid;
  logic [LANES*32-1:0]          out_addr;
  logic [LANES*32-1:0]          out_wdata;
  logic [LANES*4-1:0]           out_be;
  logic [LANES-1:0]             out_misaligned;
  logic [LANES-1:0]             out_is_store;
  logic [LANES*AL_PTR_W-1:0]    out_al_ptr;
  logic [LANES-1:0]             iq_rel_valid;
  logic [LANES*IQ_PTR_W-1:0]    iq_rel_ptr;
  logic [LANES-1:0]             iq_rel_replay;

  modport master (
    output stall, clear, in_valid, in_al_ptr, in_opnd_a, in_opnd_b, in_sel_a, in_sel_b,
           byp_data, in_imm, in_size, in_is_store, in_replay, in_iq_ptr,
           flush_req, flush_all, flush_head, flush_tail,
    input  out_valid, out_addr, out_wdata, out_be, out_misaligned, out_is_store,
           out_al_ptr, iq_rel_valid, iq_rel_ptr, iq_rel_replay
  );

  modport slave (
    input  stall, clear, in_valid, in_al_ptr, in_opnd_a, in_opnd_b, in_sel_a, in_sel_b,
           byp_data, in_imm, in_size, in_is_store, in_replay, in_iq_ptr,
           flush_req, flush_all, flush_head, flush_tail,
    output out_valid, out_addr, out_wdata, out_be, out_misaligned, out_is_store,
           out_al_ptr, iq_rel_valid, iq_rel_ptr, iq_rel_replay
  );
endinterface

// File: rtl/mem_address_exec_stage_agu.sv
// Combinational address-generation lane.
// Resolves base/store-data operands through the bypass select, forms the
// effective address, checks alignment, builds byte enables and formats store data.
//   opnd_a_i/opnd_b_i : register-read base / store-data operands
//   sel_a_i/sel_b_i   : bypass select codes
//   byp_data_i        : bypass network results
//   imm_i, size_i, is_store_i, al_ptr_i : op attributes
//   res_o             : lane result record
module mem_agu_lane
  import mem_address_exec_stage_pkg::*;
#(
  parameter int unsigned BYP_SRC = 2
) (
  input  logic [31:0]         opnd_a_i,
  input  logic [31:0]         opnd_b_i,
  input  logic [SelW-1:0]     sel_a_i,
  input  logic [SelW-1:0]     sel_b_i,
  input  logic [BYP_SRC*32-1:0] byp_data_i,
  input  logic [11:0]         imm_i,
  input  logic [1:0]          size_i,
  input  logic                is_store_i,
  input  logic [AlPtrW-1:0]   al_ptr_i,
  output lane_res_t           res_o
);

  // Codes above BYP_SRC have no source and resolve to zero.
  function automatic logic [31:0] sel_opnd(input logic [31:0]         opnd,
                                           input logic [SelW-1:0]     sel,
                                           input logic [BYP_SRC*32-1:0] byp);
    logic [31:0] r;
    r = '0;
    if (sel == '0) r = opnd;
    for (int unsigned k = 0; k < BYP_SRC; k++) begin
      if (sel == SelW'(k + 1)) r = byp[k*32 +: 32];
    end
    return r;
  endfunction

  logic [31:0]      base;
  logic [31:0]      sdata;
  logic [31:0]      addr;
  logic             misaligned;
  logic [3:0]       be;
  logic [31:0]      wdata;
  mem_access_size_e size;

  always_comb begin
    base  = sel_opnd(opnd_a_i, sel_a_i, byp_data_i);
    sdata = sel_opnd(opnd_b_i, sel_b_i, byp_data_i);
    addr  = base + {{20{imm_i[11]}}, imm_i};
    size  = mem_access_size_e'(size_i);

    misaligned = 1'b0;
    be         = 4'b0000;
    wdata      = '0;
    case (size)
      SizeByte: begin
        be    = 4'b0001 << addr[1:0];
        wdata = {4{sdata[7:0]}};
      end
      SizeHalf: begin
        misaligned = addr[0];
        be         = 4'b0011 << addr[1:0];
        wdata      = {2{sdata[15:0]}};
      end
      SizeWord: begin
        misaligned = (addr[1:0] != 2'b00);
        be         = 4'b1111;
        wdata      = sdata;
      end
      default: misaligned = 1'b1;
    endcase

    if (misaligned) be = 4'b0000;
    if (!is_store_i) wdata = '0;

    res_o            = '0;
    res_o.addr       = addr;
    res_o.wdata      = wdata;
    res_o.be         = be;
    res_o.misaligned = misaligned;
    res_o.is_store   = is_store_i;
    res_o.al_ptr     = al_ptr_i;
  end

endmodule

// File: rtl/mem_address_exec_stage.sv
// Memory-pipe execution stage between register read and cache access.
// Captures each lane's op, runs it through an AGU lane and registers the
// result; handles stall hold, clear, selective flush and the one-shot
// issue-queue release pulse.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of mem_address_exec_stage_if (all other signals)
module mem_address_exec_stage
  import mem_address_exec_stage_pkg::*;
#(
  parameter int unsigned LANES    = 2,
  parameter int unsigned AL_PTR_W = AlPtrW,
  parameter int unsigned IQ_PTR_W = 4,
  parameter int unsigned BYP_SRC  = 2
) (
  input logic                    clk,
  input logic                    rst,
  mem_address_exec_stage_if.slave bus
);

  lane_res_t agu_res [LANES];
  lane_res_t lane_q  [LANES];
  lane_res_t lane_d  [LANES];

  logic [LANES-1:0]          valid_q, valid_d;
  logic [LANES-1:0]          pend_q, pend_d;       // held op came in valid
  logic [LANES-1:0]          released_q, released_d;
  logic [LANES-1:0]          rel_q, rel_d;
  logic [LANES-1:0]          replay_q, replay_d;
  logic [LANES*IQ_PTR_W-1:0] iq_ptr_q, iq_ptr_d;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    mem_agu_lane #(
      .BYP_SRC (BYP_SRC)
    ) u_agu (
      .opnd_a_i   (bus.in_opnd_a[g*32 +: 32]),
      .opnd_b_i   (bus.in_opnd_b[g*32 +: 32]),
      .sel_a_i    (bus.in_sel_a[g*2 +: 2]),
      .sel_b_i    (bus.in_sel_b[g*2 +: 2]),
      .byp_data_i (bus.byp_data),
      .imm_i      (bus.in_imm[g*12 +: 12]),
      .size_i     (bus.in_size[g*2 +: 2]),
      .is_store_i (bus.in_is_store[g]),
      .al_ptr_i   (bus.in_al_ptr[g*AL_PTR_W +: AL_PTR_W]),
      .res_o      (agu_res[g])
    );
  end

  always_comb begin
    valid_d    = valid_q;
    pend_d     = pend_q;
    released_d = released_q;
    rel_d      = '0;
    replay_d   = replay_q;
    iq_ptr_d   = iq_ptr_q;
    for (int unsigned i = 0; i < LANES; i++) begin
      lane_d[i] = lane_q[i];
      if (!bus.stall) begin
        lane_d[i]     = agu_res[i];
        // Killed ops still release their issue-queue entry.
        valid_d[i]    = bus.in_valid[i] & ~bus.clear &
                        ~flush_range_hit(bus.flush_req, bus.flush_all, bus.flush_head,
                                         bus.flush_tail, bus.in_al_ptr[i*AL_PTR_W +: AL_PTR_W]);
        pend_d[i]     = bus.in_valid[i];
        rel_d[i]      = bus.in_valid[i];
        released_d[i] = 1'b0;
        replay_d[i]   = bus.in_replay[i];
        iq_ptr_d[i*IQ_PTR_W +: IQ_PTR_W] = bus.in_iq_ptr[i*IQ_PTR_W +: IQ_PTR_W];
      end else begin
        // Clear/flush still kill a held op in place; its other fields hold.
        valid_d[i]    = valid_q[i] & ~bus.clear &
                        ~flush_range_hit(bus.flush_req, bus.flush_all, bus.flush_head,
                                         bus.flush_tail, lane_q[i].al_ptr);
        rel_d[i]      = pend_q[i] & ~(released_q[i] | rel_q[i]);
        released_d[i] = released_q[i] | rel_q[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= '0;
      pend_q     <= '0;
      released_q <= '0;
      rel_q      <= '0;
      replay_q   <= '0;
      iq_ptr_q   <= '0;
      for (int unsigned i = 0; i < LANES; i++) lane_q[i] <= '0;
    end else begin
      valid_q    <= valid_d;
      pend_q     <= pend_d;
      released_q <= released_d;
      rel_q      <= rel_d;
      replay_q   <= replay_d;
      iq_ptr_q   <= iq_ptr_d;
      for (int unsigned i = 0; i < LANES; i++) lane_q[i] <= lane_d[i];
    end
  end

  always_comb begin
    bus.out_valid      = valid_q;
    bus.iq_rel_valid   = rel_q;
    bus.iq_rel_replay  = replay_q;
    bus.iq_rel_ptr     = iq_ptr_q;
    bus.out_addr       = '0;
    bus.out_wdata      = '0;
    bus.out_be         = '0;
    bus.out_misaligned = '0;
    bus.out_is_store   = '0;
    bus.out_al_ptr     = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      bus.out_addr[i*32 +: 32]             = lane_q[i].addr;
      bus.out_wdata[i*32 +: 32]            = lane_q[i].wdata;
      bus.out_be[i*4 +: 4]                 = lane_q[i].be;
      bus.out_misaligned[i]                = lane_q[i].misaligned;
      bus.out_is_store[i]                  = lane_q[i].is_store;
      bus.out_al_ptr[i*AL_PTR_W +: AL_PTR_W] = lane_q[i].al_ptr;
    end
  end

endmodule

// File: tb/tb_mem_address_exec_stage.sv
module tb_mem_address_exec_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_address_exec_stage_if bus ();

  mem_address_exec_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic        lane;
    logic [31:0] base;
    logic [11:0] imm;
    logic [1:0]  size;
    logic        st;
    logic [31:0] data;
    logic [1:0]  sel_a;
    logic [1:0]  sel_b;
    logic [31:0] byp0;
    logic [31:0] byp1;
    logic [5:0]  al;
    logic [3:0]  iq;
    logic        rep;
    logic        freq;
    logic        fall;
    logic [5:0]  fh;
    logic [5:0]  ft;
    logic        clr;
    logic        e_valid;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [3:0]  e_be;
    logic        e_mis;
  } vec_t;

  typedef struct packed {
    logic        lane;
    logic        valid;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        mis;
    logic        st;
    logic [5:0]  al;
    logic [3:0]  iq;
    logic        rep;
  } exp_t;

  localparam int NV = 21;
  vec_t vt [NV];
  exp_t sb [$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic idle();
    bus.stall = 0; bus.clear = 0; bus.in_valid = '0; bus.in_al_ptr = '0;
    bus.in_opnd_a = '0; bus.in_opnd_b = '0; bus.in_sel_a = '0; bus.in_sel_b = '0;
    bus.byp_data = '0; bus.in_imm = '0; bus.in_size = '0; bus.in_is_store = '0;
    bus.in_replay = '0; bus.in_iq_ptr = '0; bus.flush_req = 0; bus.flush_all = 0;
    bus.flush_head = '0; bus.flush_tail = '0;
  endtask

  task automatic drive_op(input int l, input logic [31:0] base, input logic [1:0] size,
                          input logic st, input logic [31:0] data, input logic [5:0] al,
                          input logic [3:0] iq);
    bus.in_valid[l] = 1'b1;
    bus.in_opnd_a[l*32 +: 32] = base;
    bus.in_opnd_b[l*32 +: 32] = data;
    bus.in_size[l*2 +: 2] = size;
    bus.in_is_store[l] = st;
    bus.in_al_ptr[l*6 +: 6] = al;
    bus.in_iq_ptr[l*4 +: 4] = iq;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 32'(bus.out_valid), 0);
    check({tag, "_addr0"}, bus.out_addr[31:0], 0);
    check({tag, "_addr1"}, bus.out_addr[63:32], 0);
    check({tag, "_wdata1"}, bus.out_wdata[63:32], 0);
    check({tag, "_be"}, 32'(bus.out_be), 0);
    check({tag, "_mis_st"}, 32'({bus.out_misaligned, bus.out_is_store}), 0);
    check({tag, "_al"}, 32'(bus.out_al_ptr), 0);
    check({tag, "_rel"}, 32'({bus.iq_rel_valid, bus.iq_rel_replay, bus.iq_rel_ptr}), 0);
  endtask

  initial begin
    vt[0]  = '{lane:0, base:32'h1000, imm:12'hFFC, size:2, al:5, iq:1,
               e_valid:1, e_addr:32'h0000_0FFC, e_be:4'hF, default:'0};
    vt[1]  = '{lane:1, base:32'h2003, size:1, st:1, data:32'hABCD, al:6, iq:2,
               e_valid:1, e_addr:32'h2003, e_wdata:32'hABCD_ABCD, e_be:4'h0, e_mis:1,
               default:'0};
    vt[2]  = '{lane:0, base:32'h2002, size:1, st:1, data:32'hABCD, al:7, iq:3, rep:1,
               e_valid:1, e_addr:32'h2002, e_wdata:32'hABCD_ABCD, e_be:4'hC, default:'0};
    vt[3]  = '{lane:1, sel_a:2, byp1:32'h8000, imm:12'h010, size:2, al:8, iq:4,
               e_valid:1, e_addr:32'h8010, e_be:4'hF, default:'0};
    vt[4]  = '{lane:1, base:32'h3001, imm:12'h002, size:0, st:1, data:32'h1234_565A,
               al:9, iq:5, e_valid:1, e_addr:32'h3003, e_wdata:32'h5A5A_5A5A, e_be:4'h8,
               default:'0};
    vt[5]  = '{lane:0, base:32'h4000, size:2, st:1, data:32'h1111_1111, sel_b:1,
               byp0:32'hDEAD_BEEF, al:10, iq:6, e_valid:1, e_addr:32'h4000,
               e_wdata:32'hDEAD_BEEF, e_be:4'hF, default:'0};
    vt[6]  = '{lane:0, base:32'h9999_0000, sel_a:3, byp0:32'h5555, byp1:32'h6666,
               imm:12'h020, size:2, al:11, iq:7, e_valid:1, e_addr:32'h20, e_be:4'hF,
               default:'0};
    vt[7]  = '{lane:1, base:32'hFFFF_FFFC, imm:12'h008, size:2, al:12, iq:8,
               e_valid:1, e_addr:32'h4, e_be:4'hF, default:'0};
    vt[8]  = '{lane:0, base:32'h100, size:3, al:13, iq:9,
               e_valid:1, e_addr:32'h100, e_be:4'h0, e_mis:1, default:'0};
    vt[9]  = '{lane:1, base:32'h101, size:2, st:1, data:32'hCAFE_F00D, al:14, iq:10, rep:1,
               e_valid:1, e_addr:32'h101, e_wdata:32'hCAFE_F00D, e_be:4'h0, e_mis:1,
               default:'0};
    vt[10] = '{lane:0, base:32'h500, size:2, al:62, iq:11, freq:1, fh:60, ft:3,
               e_valid:0, e_addr:32'h500, e_be:4'hF, default:'0};
    vt[11] = '{lane:1, base:32'h504, size:2, al:1, iq:12, freq:1, fh:60, ft:3,
               e_valid:0, e_addr:32'h504, e_be:4'hF, default:'0};
    vt[12] = '{lane:0, base:32'h508, size:2, al:10, iq:13, freq:1, fh:60, ft:3,
               e_valid:1, e_addr:32'h508, e_be:4'hF, default:'0};
    vt[13] = '{lane:1, base:32'h50C, size:2, al:7, iq:14, freq:1, fh:7, ft:7,
               e_valid:1, e_addr:32'h50C, e_be:4'hF, default:'0};
    vt[14] = '{lane:0, base:32'h510, size:2, al:20, iq:15, freq:1, fall:1, fh:7, ft:7,
               e_valid:0, e_addr:32'h510, e_be:4'hF, default:'0};
    vt[15] = '{lane:1, base:32'h514, size:2, al:21, iq:1, clr:1,
               e_valid:0, e_addr:32'h514, e_be:4'hF, default:'0};
    vt[16] = '{lane:0, base:32'h518, size:2, al:9, iq:2, freq:1, fh:3, ft:9,
               e_valid:1, e_addr:32'h518, e_be:4'hF, default:'0};
    vt[17] = '{lane:1, base:32'h51C, size:2, al:3, iq:3, freq:1, fh:3, ft:9,
               e_valid:0, e_addr:32'h51C, e_be:4'hF, default:'0};
    vt[18] = '{lane:0, base:32'h10, imm:12'h800, size:2, al:4, iq:4,
               e_valid:1, e_addr:32'hFFFF_F810, e_be:4'hF, default:'0};
    vt[19] = '{lane:1, base:32'h2, size:0, data:32'hFFFF_FFFF, al:5, iq:5,
               e_valid:1, e_addr:32'h2, e_be:4'h4, default:'0};
    vt[20] = '{lane:0, sel_a:1, byp0:32'h7, base:32'hFFFF_0000, imm:12'hFFF, size:1,
               st:1, data:32'h0000_BEEF, al:6, iq:6, e_valid:1, e_addr:32'h6,
               e_wdata:32'hBEEF_BEEF, e_be:4'hC, default:'0};

    idle();
    repeat (2) @(posedge clk);
    #1 check_all_zero("reset");
    @(negedge clk); rst = 0;

    for (int i = 0; i < NV; i++) begin
      int   l;
      exp_t e;
      logic [1:0] m;
      @(negedge clk);
      idle();
      l = int'(vt[i].lane);
      drive_op(l, vt[i].base, vt[i].size, vt[i].st, vt[i].data, vt[i].al, vt[i].iq);
      bus.in_imm[l*12 +: 12] = vt[i].imm;
      bus.in_sel_a[l*2 +: 2] = vt[i].sel_a;
      bus.in_sel_b[l*2 +: 2] = vt[i].sel_b;
      bus.in_replay[l] = vt[i].rep;
      bus.byp_data = {vt[i].byp1, vt[i].byp0};
      bus.flush_req = vt[i].freq; bus.flush_all = vt[i].fall;
      bus.flush_head = vt[i].fh; bus.flush_tail = vt[i].ft;
      bus.clear = vt[i].clr;
      sb.push_back('{lane:vt[i].lane, valid:vt[i].e_valid, addr:vt[i].e_addr,
                     wdata:vt[i].e_wdata, be:vt[i].e_be, mis:vt[i].e_mis, st:vt[i].st,
                     al:vt[i].al, iq:vt[i].iq, rep:vt[i].rep});
      @(posedge clk); #1;
      if (sb.size() == 0) begin
        check($sformatf("v%0d_sb_empty", i), 1, 0);
        continue;
      end
      e = sb.pop_front();
      l = int'(e.lane);
      m = e.lane ? 2'b10 : 2'b01;
      check($sformatf("v%0d_valid", i), 32'(bus.out_valid), e.valid ? 32'(m) : 0);
      check($sformatf("v%0d_addr", i), bus.out_addr[l*32 +: 32], e.addr);
      check($sformatf("v%0d_wdata", i), bus.out_wdata[l*32 +: 32], e.wdata);
      check($sformatf("v%0d_be", i), 32'(bus.out_be[l*4 +: 4]), 32'(e.be));
      check($sformatf("v%0d_mis", i), 32'(bus.out_misaligned[l]), 32'(e.mis));
      check($sformatf("v%0d_st", i), 32'(bus.out_is_store[l]), 32'(e.st));
      check($sformatf("v%0d_al", i), 32'(bus.out_al_ptr[l*6 +: 6]), 32'(e.al));
      check($sformatf("v%0d_rel", i), 32'(bus.iq_rel_valid), 32'(m));
      check($sformatf("v%0d_relptr", i), 32'(bus.iq_rel_ptr[l*4 +: 4]), 32'(e.iq));
      check($sformatf("v%0d_relrep", i), 32'(bus.iq_rel_replay[l]), 32'(e.rep));
    end

    // Release pulse lasts one cycle.
    @(negedge clk); idle();
    @(posedge clk); #1;
    check("idle_rel", 32'(bus.iq_rel_valid), 0);
    check("idle_valid", 32'(bus.out_valid), 0);

    // Stall hold with a mid-stall flush of the held op.
    @(negedge clk); idle();
    drive_op(0, 32'h600, 2'd2, 1'b0, 32'h0, 6'd30, 4'd9);
    @(posedge clk); #1;
    check("stl_cap_valid", 32'(bus.out_valid), 1);
    check("stl_cap_rel", 32'(bus.iq_rel_valid), 1);
    @(negedge clk);
    bus.stall = 1; bus.in_valid = 2'b11; bus.in_opnd_a[31:0] = 32'h700;
    @(posedge clk); #1;
    check("stl1_valid", 32'(bus.out_valid), 1);
    check("stl1_addr", bus.out_addr[31:0], 32'h600);
    check("stl1_rel", 32'(bus.iq_rel_valid), 0);
    @(negedge clk);
    bus.flush_req = 1; bus.flush_head = 6'd28; bus.flush_tail = 6'd32;
    @(posedge clk); #1;
    check("stl2_valid", 32'(bus.out_valid), 0);
    check("stl2_addr", bus.out_addr[31:0], 32'h600);
    check("stl2_al", 32'(bus.out_al_ptr[5:0]), 30);
    check("stl2_rel", 32'(bus.iq_rel_valid), 0);
    @(negedge clk); bus.flush_req = 0;
    @(posedge clk); #1;
    check("stl3_valid", 32'(bus.out_valid), 0);
    check("stl3_rel", 32'(bus.iq_rel_valid), 0);
    check("stl3_be", 32'(bus.out_be[3:0]), 32'hF);
    @(negedge clk); idle();
    @(posedge clk); #1;
    check("stl_end_rel", 32'(bus.iq_rel_valid), 0);

    // Clear during stall kills the held op.
    @(negedge clk); idle();
    drive_op(1, 32'h900, 2'd2, 1'b0, 32'h0, 6'd33, 4'd7);
    @(posedge clk); #1;
    check("clr_cap_valid", 32'(bus.out_valid), 2);
    @(negedge clk); bus.stall = 1; bus.clear = 1;
    @(posedge clk); #1;
    check("clr_stl_valid", 32'(bus.out_valid), 0);
    check("clr_stl_addr", bus.out_addr[63:32], 32'h900);

    // Asynchronous reset while a valid op is held.
    @(negedge clk); idle();
    drive_op(1, 32'h800, 2'd2, 1'b1, 32'h1234_5678, 6'd40, 4'd11);
    @(posedge clk); #1;
    check("ar_cap_valid", 32'(bus.out_valid), 2);
    @(negedge clk); bus.stall = 1; bus.in_valid = '0;
    @(posedge clk); #1;
    check("ar_hold_valid", 32'(bus.out_valid), 2);
    #2 rst = 1;
    #1 check_all_zero("async_rst");
    @(negedge clk); rst = 0; idle();
    @(posedge clk); #1;
    check("ar_after_rel", 32'(bus.iq_rel_valid), 0);
    check("ar_after_valid", 32'(bus.out_valid), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_address_exec_stage.md
Name: mem_address_exec_stage

Overview:
- Memory-pipe execution stage directly downstream of the memory register-read stage.
- Latches each lane's register-read output and resolves operands through the bypass select.
- Computes the effective address, alignment, byte enables and formatted store data, and drives one registered result per lane to the cache-access stage.
- Also returns the issue-queue release notification and applies stall, clear and selective flush.

Parameters:
- LANES, 2, number of memory issue lanes.
- AL_PTR_W, 6, active-list pointer width.
- IQ_PTR_W, 4, issue-queue pointer width.
- BYP_SRC, 2, number of bypass sources; select code 0 = register-read operand, k = bypass source k-1.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- stall  in  1  backend stall; hold all state.
- clear  in  1  backend clear; kill captured ops.
- in_valid  in  LANES  op valid from register read.
- in_al_ptr  in  LANES*AL_PTR_W  active-list pointer.
- in_opnd_a, in_opnd_b  in  LANES*32 each  register-read operands (a = base, b = store data).
- in_sel_a, in_sel_b  in  LANES*2 each  bypass select codes.
- byp_data  in  BYP_SRC*32  bypass network results.
- in_imm  in  LANES*12  signed address offset.
- in_size  in  LANES*2  access size: 0 byte, 1 half, 2 word, 3 reserved.
- in_is_store  in  LANES  store flag.
- in_replay  in  LANES  replay flag from register read.
- in_iq_ptr  in  LANES*IQ_PTR_W  issue-queue entry.
- flush_req  in  1  recovery selective-flush active.
- flush_all  in  1  flush every op.
- flush_head, flush_tail  in  AL_PTR_W each  flush range [head, tail).
- out_valid  out  LANES  result valid.
- out_addr  out  LANES*32  effective address.
- out_wdata  out  LANES*32  formatted store data.
- out_be  out  LANES*4  byte enables.
- out_misaligned  out  LANES  alignment fault.
- out_is_store  out  LANES  store flag.
- out_al_ptr  out  LANES*AL_PTR_W  active-list pointer.
- iq_rel_valid  out  LANES  issue-queue release pulse.
- iq_rel_ptr  out  LANES*IQ_PTR_W  released entry.
- iq_rel_replay  out  LANES  release is a replay.

Behaviour:
- Reset: every output register and the per-lane released bits go to 0, asynchronously. Reset mid-stall also drops held ops.
- Latency: one cycle. At posedge with !stall, all out_* capture the computed values of the in_* lane data.
- out_valid: captured as in_valid & !clear & !flush_hit(in_al_ptr).
- flush_hit(p): flush_req and (flush_all, or, if head<tail then head<=p<tail, if head>tail then p>=head or p<tail, if head==tail then empty range).
- Stall: all outputs hold. If a flush hits a held lane's out_al_ptr during stall, that lane's out_valid is cleared in place; its other fields hold.
- clear and flush take precedence over stall for the valid bit only.
- Operand select: code 0 selects in_opnd; code 1..BYP_SRC selects byp_data source code-1. Codes above BYP_SRC select 0.
- Address: base + sign-extended imm, mod 2^32. Wrap past 0xFFFFFFFF is legal and not a fault.
- Misaligned: half with addr[0]=1; word with addr[1:0]!=0; size 3 always.
- out_be is 0 when misaligned. Otherwise:
  - byte: 0001<<addr[1:0]
  - half: 0011<<addr[1:0]
  - word: 1111
- Store data:
  - byte: opnd_b[7:0] replicated 4 times.
  - half: opnd_b[15:0] replicated twice.
  - word: passed as is.
  - loads: out_wdata is 0.
- Issue-queue release:
  - iq_rel_valid is asserted in the cycle after capture of an in_valid op, including one killed by flush or clear, so the entry is freed.
  - iq_rel_replay = captured in_replay.
  - Pulses exactly once per op. A per-lane released bit suppresses repeats while stall holds the op; the bit is cleared on the next capture.

Decomposition:
- Shared package (MemExecTypes):
  - MemAccessSize enum.
  - Lane record struct (addr, wdata, be, misaligned, is_store, al_ptr).
  - Bypass select width constant.
  - flush_range_hit function, reused by other stages.
- Sub-module mem_agu_lane: combinational per-lane operand select, address, alignment, byte enables and store formatting. The top holds the registers, flush and release logic.

Test Plan:
- Reset release; base 0x1000, imm -4, word load, sel 0 → next cycle out_addr 0x00000FFC, be 1111, misaligned 0, iq_rel_valid 1 for one cycle.
- Half store at base 0x2003, imm 0, data 0xABCD → misaligned 1, be 0000; same op at 0x2002 → be 1100, wdata 0xABCDABCD.
- sel_a 2 with byp_data[1]=0x8000 overriding in_opnd_a=0 → out_addr 0x8000 + imm.
- Flush head 60, tail 3: al_ptr 62 and 1 killed, 10 kept; head==tail with flush_all 0 → nothing killed; killed ops still pulse iq_rel_valid.
- Capture, then stall 3 cycles with a flush hitting the held al_ptr mid-stall → out_valid drops immediately, other outputs hold, iq_rel_valid pulsed once only.
- Assert rst asynchronously mid-cycle with valid ops held → all outputs 0 before the next edge.
